// File: rtl/rx_sync_unstuff_pkg.sv
// Shared constants for the USB receive path: FSM encodings, stuffing limit and
// SYNC terminator. The bit-stuffer (hs_bs) pulls its stuff limit from here too.
package rx_sync_unstuff_pkg;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_EOP_GAP = 2'd2;

  localparam int STUFF_LIMIT_DEF    = 6;
  localparam int MIN_SYNC_ZEROS_DEF = 5;
  localparam int BYTE_W             = 8;

  localparam logic SYNC_TERM = 1'b1;

  // Only zero/non-zero of the byte counter matters, so it simply sticks at 7.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/rx_sync_unstuff_if.sv
// Serial-in / byte-out bundle between the NRZI decoder side and the byte path.
interface rx_sync_unstuff_if;
  import rx_sync_unstuff_pkg::*;

  logic              rx_en;
  logic              dataIn;
  logic [BYTE_W-1:0] dataOut;
  logic              RX_VALID;
  logic              RX_ACTIVE;
  logic              RX_ERROR;
  logic              STUFF_DROP;

  modport master (
    output rx_en, dataIn,
    input  dataOut, RX_VALID, RX_ACTIVE, RX_ERROR, STUFF_DROP
  );

  modport slave (
    input  rx_en, dataIn,
    output dataOut, RX_VALID, RX_ACTIVE, RX_ERROR, STUFF_DROP
  );
endinterface

// File: rtl/rx_sync_detect.sv
// SYNC hunter: counts the run of decoded 0s and flags the terminating 1 when
// the run was long enough.
module rx_sync_detect
  import rx_sync_unstuff_pkg::*;
#(
  parameter int MIN_SYNC_ZEROS = MIN_SYNC_ZEROS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic hunting,
  input  logic rx_en,
  input  logic din,
  output logic sync_hit
);
  localparam logic [2:0] MIN_Z = 3'(MIN_SYNC_ZEROS);

  logic [2:0] zero_cnt;

  assign sync_hit = hunting && rx_en && (din == SYNC_TERM) && (zero_cnt >= MIN_Z);

  // Held at zero outside HUNT so EOP-trailing bits never seed a false SYNC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_cnt <= '0;
    end else if (!hunting || !rx_en || din) begin
      zero_cnt <= '0;
    end else if (zero_cnt != 3'd7) begin
      zero_cnt <= zero_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/rx_sync_unstuff.sv
// Receive stage after the NRZI decoder: SYNC hunt, bit unstuffing, LSB-first
// byte assembly and EOP / abort signalling with registered strobes.
module rx_sync_unstuff
  import rx_sync_unstuff_pkg::*;
#(
  parameter int STUFF_LIMIT    = STUFF_LIMIT_DEF,
  parameter int MIN_SYNC_ZEROS = MIN_SYNC_ZEROS_DEF
) (
  input logic              clk,
  input logic              rst,
  rx_sync_unstuff_if.slave bus
);
  localparam int            OW       = $clog2(STUFF_LIMIT + 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LIMIT);

  logic [1:0]        state;
  logic [OW-1:0]     ones_cnt;
  logic [2:0]        bit_cnt;
  logic [2:0]        byte_cnt;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] asm_byte;
  logic [BYTE_W-1:0] data_q;
  logic              valid_q, active_q, error_q, drop_q;
  logic              sync_hit;
  logic              hunting;

  assign hunting = (state == ST_HUNT);

  rx_sync_detect #(.MIN_SYNC_ZEROS(MIN_SYNC_ZEROS)) u_detect (
    .clk      (clk),
    .rst      (rst),
    .hunting  (hunting),
    .rx_en    (bus.rx_en),
    .din      (bus.dataIn),
    .sync_hit (sync_hit)
  );

  // Byte as it would look with the current bit dropped into its slot.
  always_comb begin
    asm_byte          = shreg;
    asm_byte[bit_cnt] = bus.dataIn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_HUNT;
      ones_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      drop_q  <= 1'b0;
      case (state)
        ST_HUNT: begin
          // The SYNC terminator is a 1 and already counts toward stuffing.
          if (sync_hit) begin
            state    <= ST_ACTIVE;
            active_q <= 1'b1;
            ones_cnt <= OW'(1);
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        ST_ACTIVE: begin
          if (!bus.rx_en) begin
            state    <= ST_HUNT;
            active_q <= 1'b0;
            error_q  <= 1'b1;
          end else if (ones_cnt == ONES_MAX) begin
            if (bus.dataIn) begin
              // Stuff violation is the EOP; any partial byte is dropped.
              state    <= ST_EOP_GAP;
              active_q <= 1'b0;
              error_q  <= (byte_cnt == 3'd0);
            end else begin
              drop_q   <= 1'b1;
              ones_cnt <= '0;
            end
          end else begin
            shreg    <= asm_byte;
            ones_cnt <= bus.dataIn ? ones_cnt + OW'(1) : '0;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_q   <= asm_byte;
              valid_q  <= 1'b1;
              byte_cnt <= sat_inc3(byte_cnt);
            end
          end
        end
        ST_EOP_GAP: state <= ST_HUNT;
        default: begin
          state    <= ST_HUNT;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dataOut    = data_q;
  assign bus.RX_VALID   = valid_q;
  assign bus.RX_ACTIVE  = active_q;
  assign bus.RX_ERROR   = error_q;
  assign bus.STUFF_DROP = drop_q;

endmodule

// File: tb/tb_rx_sync_unstuff.sv
// Directed scenarios plus randomized packet traffic checked against a
// bit-stream level reference model.
module tb_rx_sync_unstuff;
  localparam int STUFF = 6;
  localparam int MINZ  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  rx_sync_unstuff_if bus ();

  rx_sync_unstuff #(.STUFF_LIMIT(STUFF), .MIN_SYNC_ZEROS(MINZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (works on the raw bit history) ----------
  typedef enum int {M_HUNT, M_ACT, M_GAP} mmode_t;
  mmode_t     m_mode;
  bit         hist[$];
  bit         raw[$];
  bit         dat[$];
  int         m_nbytes;
  logic [7:0] e_dout;
  logic       e_valid, e_active, e_err, e_drop;

  function automatic int trailing_ones();
    int n = 0;
    for (int i = raw.size() - 1; i >= 0; i--) begin
      if (!raw[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic bit sync_seen();
    int s = hist.size();
    if (s < MINZ + 1 || !hist[s-1]) return 1'b0;
    for (int k = 2; k <= MINZ + 1; k++)
      if (hist[s-k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_mode = M_HUNT; hist.delete(); raw.delete(); dat.delete(); m_nbytes = 0;
    e_dout = 8'h00; e_valid = 0; e_active = 0; e_err = 0; e_drop = 0;
  endfunction

  function automatic void model_step(input bit b, input bit en);
    e_valid = 0; e_err = 0; e_drop = 0;
    case (m_mode)
      M_GAP: begin m_mode = M_HUNT; hist.delete(); end
      M_HUNT: begin
        if (!en) hist.delete();
        else begin
          hist.push_back(b);
          if (hist.size() > 8) void'(hist.pop_front());
          if (sync_seen()) begin
            m_mode = M_ACT; e_active = 1; hist.delete();
            raw.delete(); raw.push_back(1'b1); dat.delete(); m_nbytes = 0;
          end
        end
      end
      default: begin
        if (!en) begin
          m_mode = M_HUNT; e_active = 0; e_err = 1; hist.delete();
        end else if (trailing_ones() >= STUFF) begin
          if (b) begin
            m_mode = M_GAP; e_active = 0; e_err = (m_nbytes == 0);
          end else begin
            e_drop = 1; raw.push_back(1'b0);
          end
        end else begin
          raw.push_back(b); dat.push_back(b);
          if (dat.size() == 8) begin
            for (int i = 0; i < 8; i++) e_dout[i] = dat[i];
            e_valid = 1; m_nbytes++; dat.delete();
          end
        end
        if (raw.size() > 16) void'(raw.pop_front());
      end
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic b, input logic en);
    bus.dataIn = b; bus.rx_en = en;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    bus.dataIn = 1'b0; bus.rx_en = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) send(1'b0, 1'b1);
    send(1'b1, 1'b1);
  endtask

  function automatic logic [11:0] outs();
    return {bus.dataOut, bus.RX_VALID, bus.RX_ACTIVE, bus.RX_ERROR, bus.STUFF_DROP};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] b = 8'h5A;
    int act = 0;
    do_reset();
    n_chk++;
    if (outs() !== 12'h000) $display("FAIL reset_state: got %h want 000", outs());
    else n_pass++;
    send_sync();
    for (int i = 0; i < 8; i++) send(b[i], 1'b1);
    n_chk++;
    if ({bus.RX_VALID, bus.RX_ACTIVE, bus.dataOut} !== {2'b11, 8'h5A})
      $display("FAIL reset_prebyte: got v%b a%b %h want v1 a1 5a", bus.RX_VALID, bus.RX_ACTIVE, bus.dataOut);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (outs() !== 12'h000) $display("FAIL reset_async: got %h want 000", outs());
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin send(1'b0, 1'b1); act += bus.RX_ACTIVE; end
    n_chk++;
    if (act !== 0) $display("FAIL reset_idle_active: got %0d active cycles want 0", act);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] b = 8'hA5;
    int nv = 0, ne = 0, fall = -1;
    do_reset();
    for (int i = 0; i < 7; i++) send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    n_chk++;
    if ({bus.RX_ACTIVE, bus.RX_VALID} !== 2'b10)
      $display("FAIL basic_sync: got a%b v%b want a1 v0", bus.RX_ACTIVE, bus.RX_VALID);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin send(b[i], 1'b1); nv += bus.RX_VALID; ne += bus.RX_ERROR; end
    n_chk++;
    if ({bus.RX_VALID, bus.dataOut} !== {1'b1, 8'hA5})
      $display("FAIL basic_byte: got v%b %h want v1 a5", bus.RX_VALID, bus.dataOut);
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      send(1'b1, 1'b1); nv += bus.RX_VALID; ne += bus.RX_ERROR;
      if (fall < 0 && !bus.RX_ACTIVE) fall = i;
    end
    n_chk++;
    if (fall !== 5) $display("FAIL basic_eop_edge: got one #%0d want #5", fall);
    else n_pass++;
    n_chk++;
    if ({nv, ne} !== {32'd1, 32'd0}) $display("FAIL basic_counts: got valid %0d err %0d want 1 0", nv, ne);
    else n_pass++;
  endtask

  task automatic test_stuff();
    logic [8:0] seq = 9'b111_0_11111;
    logic [8:0] drops = '0;
    int ne = 0;
    do_reset();
    send_sync();
    for (int i = 0; i < 9; i++) begin send(seq[i], 1'b1); drops[i] = bus.STUFF_DROP; end
    n_chk++;
    if (drops !== 9'b000_1_00000) $display("FAIL stuff_drop: got %b want 000100000", drops);
    else n_pass++;
    n_chk++;
    if ({bus.RX_VALID, bus.dataOut} !== {1'b1, 8'hFF})
      $display("FAIL stuff_byte: got v%b %h want v1 ff", bus.RX_VALID, bus.dataOut);
    else n_pass++;
    for (int i = 0; i < 7; i++) begin send(1'b1, 1'b1); ne += bus.RX_ERROR; end
    n_chk++;
    if ({bus.RX_ACTIVE, ne} !== {1'b0, 32'd0}) $display("FAIL stuff_eop: got a%b err %0d want a0 0", bus.RX_ACTIVE, ne);
    else n_pass++;
  endtask

  task automatic test_empty();
    int nv = 0, ne = 0, eidx = -1;
    do_reset();
    send_sync();
    for (int i = 0; i < 7; i++) begin
      send(1'b1, 1'b1); nv += bus.RX_VALID; ne += bus.RX_ERROR;
      if (bus.RX_ERROR && eidx < 0) eidx = i;
    end
    n_chk++;
    if ({nv, ne, eidx} !== {32'd0, 32'd1, 32'd5})
      $display("FAIL empty_pkt: got valid %0d err %0d at %0d want 0 1 5", nv, ne, eidx);
    else n_pass++;
    n_chk++;
    if (bus.RX_ACTIVE !== 1'b0) $display("FAIL empty_active: got %b want 0", bus.RX_ACTIVE);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] b = 8'h3C;
    logic [3:0] p = 4'b0101;
    int nv = 0, ne = 0;
    do_reset();
    send_sync();
    for (int i = 0; i < 8; i++) send(b[i], 1'b1);
    n_chk++;
    if ({bus.RX_VALID, bus.dataOut} !== {1'b1, 8'h3C})
      $display("FAIL abort_byte: got v%b %h want v1 3c", bus.RX_VALID, bus.dataOut);
    else n_pass++;
    for (int i = 0; i < 4; i++) send(p[i], 1'b1);
    send(1'b0, 1'b0);
    n_chk++;
    if ({bus.RX_ACTIVE, bus.RX_ERROR, bus.RX_VALID} !== 3'b010)
      $display("FAIL abort_edge: got a%b e%b v%b want a0 e1 v0", bus.RX_ACTIVE, bus.RX_ERROR, bus.RX_VALID);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin send(1'b1, 1'b0); nv += bus.RX_VALID; ne += bus.RX_ERROR; end
    n_chk++;
    if ({nv, ne, bus.dataOut} !== {32'd0, 32'd0, 8'h3C})
      $display("FAIL abort_after: got valid %0d err %0d %h want 0 0 3c", nv, ne, bus.dataOut);
    else n_pass++;
  endtask

  task automatic test_short_sync();
    logic [7:0] b = 8'h55;
    logic [7:0] g = 8'h96;
    int na = 0, nv = 0;
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b0, 1'b1);
    send(1'b1, 1'b1); na += bus.RX_ACTIVE;
    for (int i = 0; i < 8; i++) begin send(b[i], 1'b1); na += bus.RX_ACTIVE; nv += bus.RX_VALID; end
    n_chk++;
    if ({na, nv} !== {32'd0, 32'd0}) $display("FAIL short_sync: got active %0d valid %0d want 0 0", na, nv);
    else n_pass++;
    send_sync();
    for (int i = 0; i < 8; i++) send(g[i], 1'b1);
    n_chk++;
    if ({bus.RX_VALID, bus.dataOut} !== {1'b1, 8'h96})
      $display("FAIL short_resume: got v%b %h want v1 96", bus.RX_VALID, bus.dataOut);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] stim[$];   // {en, bit}
    int ones;
    int nerr = 0;
    do_reset();
    model_reset();
    for (int p = 0; p < 60; p++) begin
      stim.delete();
      for (int i = $urandom_range(0, 6); i > 0; i--) stim.push_back({($urandom_range(0, 9) != 0), 1'b0});
      if ($urandom_range(0, 4) == 0) begin
        for (int i = $urandom_range(1, 4); i > 0; i--) stim.push_back(2'b10);
        stim.push_back(2'b11);
        for (int i = $urandom_range(0, 8); i > 0; i--) stim.push_back({1'b1, 1'($urandom_range(0, 1))});
      end
      for (int i = $urandom_range(5, 8); i > 0; i--) stim.push_back(2'b10);
      stim.push_back(2'b11);
      ones = 1;
      for (int nb = $urandom_range(0, 3); nb > 0; nb--) begin
        logic [7:0] v = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        for (int i = 0; i < 8; i++) begin
          stim.push_back({1'b1, v[i]});
          ones = v[i] ? ones + 1 : 0;
          if (ones == STUFF) begin stim.push_back(2'b10); ones = 0; end
        end
      end
      if ($urandom_range(0, 5) == 0) begin
        for (int i = $urandom_range(0, 7); i > 0; i--) stim.push_back({1'b1, 1'($urandom_range(0, 1))});
        for (int i = $urandom_range(1, 3); i > 0; i--) stim.push_back({1'b0, 1'($urandom_range(0, 1))});
      end else begin
        for (int i = 0; i < 7; i++) stim.push_back(2'b11);
      end
      foreach (stim[i]) begin
        send(stim[i][0], stim[i][1]);
        model_step(stim[i][0], stim[i][1]);
        n_chk++;
        if (outs() !== {e_dout, e_valid, e_active, e_err, e_drop}) begin
          nerr++;
          if (nerr <= 10)
            $display("FAIL random_p%0d: got %h want %h", p, outs(), {e_dout, e_valid, e_active, e_err, e_drop});
        end else n_pass++;
      end
    end
  endtask

  initial begin
    bus.rx_en = 1'b1;
    bus.dataIn = 1'b0;
    test_reset();
    test_basic();
    test_stuff();
    test_empty();
    test_abort();
    test_short_sync();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_sync_unstuff.md
Name: rx_sync_unstuff

Overview:
Receive-path stage placed directly downstream of NRZI_decoder and upstream of the receive byte path (sh_bus / RX_SM).
- Takes one NRZI-decoded serial bit per clk.
- Hunts for the decoded SYNC pattern, removes stuffed bits and assembles LSB-first bytes.
- Detects EOP as a bit-stuff violation, and reports framing and empty-packet errors with byte strobes.

Parameters:
- STUFF_LIMIT, 6, number of consecutive 1s after which the next bit must be a stuffed 0.
- MIN_SYNC_ZEROS, 5, minimum run of 0s that must precede the terminating 1 of SYNC.

Ports:
- clk  input  1  receive clock, one serial bit per rising edge
- rst  input  1  asynchronous, active-high reset
- rx_en  input  1  receiver enable; low forces return to HUNT
- dataIn  input  1  decoded serial bit from NRZI_decoder
- dataOut  output  8  assembled byte, LSB = first received bit
- RX_VALID  output  1  one-cycle strobe: dataOut holds a new byte
- RX_ACTIVE  output  1  high from SYNC detection until EOP/abort
- RX_ERROR  output  1  one-cycle strobe on empty packet or abort
- STUFF_DROP  output  1  one-cycle strobe: current input bit discarded as stuffing

Behaviour:
- Reset (async, rst=1): state=HUNT; dataOut=8'h00; RX_VALID=0, RX_ACTIVE=0, RX_ERROR=0, STUFF_DROP=0; all counters cleared. Reset mid-packet discards the partial byte with no error strobe.
- All outputs are registered. Strobes are high for exactly the cycle after the sampling edge and then clear.
- States: HUNT, ACTIVE, EOP_GAP.
- HUNT:
  - zero_cnt counts consecutive 0s, saturating at 7.
  - A 1 with zero_cnt >= MIN_SYNC_ZEROS, while rx_en=1, moves to ACTIVE.
  - On that edge: RX_ACTIVE<=1, ones_cnt<=1 (the SYNC terminator counts toward stuffing), bit_cnt<=0, byte_cnt<=0.
  - A 1 with a shorter zero run resets zero_cnt and is ignored.
- ACTIVE, per edge:
  - ones_cnt==STUFF_LIMIT and dataIn=0: bit dropped; STUFF_DROP<=1; ones_cnt<=0; bit_cnt unchanged.
  - ones_cnt==STUFF_LIMIT and dataIn=1: EOP. RX_ACTIVE<=0; state<=EOP_GAP; partial byte (bit_cnt 0..7) discarded silently. RX_ERROR<=1 if byte_cnt==0.
  - Otherwise: shift dataIn into bit position bit_cnt; ones_cnt <= dataIn ? ones_cnt+1 : 0; bit_cnt++.
    - When the 8th bit is taken: dataOut<=byte, RX_VALID<=1, bit_cnt<=0, byte_cnt++ (3-bit saturating; only zero/non-zero matters).
  - Latency: RX_VALID and dataOut are visible in the cycle after the edge sampling the 8th data bit.
  - The 8th data bit and a following stuff drop may occur on consecutive edges; both strobes behave independently.
- Abort: rx_en=0 in ACTIVE → state<=HUNT, RX_ACTIVE<=0, RX_ERROR<=1, partial byte discarded. rx_en=0 in HUNT/EOP_GAP: no error, remain/return to HUNT.
- EOP_GAP: one cycle, then HUNT with zero_cnt=0. Prevents EOP ones from being read as a SYNC terminator.
- Simultaneous events: EOP on the same edge as rx_en falling → abort takes priority (RX_ERROR=1).
- RX_ACTIVE never rises in the same cycle that RX_VALID is high for the first byte. The first byte needs at least 8 more edges.

Decomposition:
- Shared package/header: state encodings (HUNT, ACTIVE, EOP_GAP), default STUFF_LIMIT=6, SYNC terminator constant. The same constants are reused by hs_bs for the stuff limit.
- One natural sub-module, rx_sync_detect: HUNT-state zero-run counter plus terminator compare, outputting a single sync_hit pulse.
- Unstuff/byte assembly stays in the top-level.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately, dataOut=8'h00. Release, drive 0s → RX_ACTIVE stays 0.
2. SYNC 0000_0001, then 0xA5 LSB-first (1,0,1,0,0,1,0,1), then 1111111 → RX_ACTIVE rises after the SYNC '1' edge; single RX_VALID with dataOut=8'hA5; RX_ACTIVE falls at the violation edge; RX_ERROR=0.
3. SYNC, then 0xFF sent as 1,1,1,1,1,0(stuffed),1,1,1, then EOP → STUFF_DROP pulses once on the stuffed-0 edge; RX_VALID with dataOut=8'hFF; no error.
4. SYNC immediately followed by 1111111 → RX_ACTIVE high then low; RX_ERROR pulses once; RX_VALID never asserts.
5. SYNC, 0x3C, then 4 bits of the next byte, then rx_en=0 → one RX_VALID (8'h3C), then RX_ACTIVE=0 and RX_ERROR=1 the next cycle; the partial byte never appears on dataOut.
6. Short SYNC (4 zeros then 1), then 8'h55 bits → no RX_ACTIVE, no RX_VALID. Next, a full SYNC → normal reception resumes.
